// File: rtl/gw_pkg.sv
// Shared types and width helpers for the gray_world frame sequencer and its watchdog.
package gw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } gw_state_e;

  localparam int FRAME_CNT_W = 16;

  // Bits needed to hold every value 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int col_w(input int ncol);
    return cnt_w(ncol);
  endfunction

  function automatic int row_w(input int nrows);
    return cnt_w(nrows);
  endfunction

endpackage

// File: rtl/gw_frame_sequencer_if.sv
// Slave AXI-Stream video sideband seen by the frame sequencer (no tready: the stream never stalls).
interface gw_frame_sequencer_if;
  logic tvalid;
  logic tuser;
  logic tlast;

  modport master (output tvalid, output tuser, output tlast);
  modport slave  (input  tvalid, input  tuser, input  tlast);
endinterface

// File: rtl/gw_timeout_cnt.sv
// Idle-cycle watchdog: counts enabled cycles, expires on the TIMEOUT-th one, then restarts from zero.
module gw_timeout_cnt
  import gw_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = cnt_w(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) cnt_d = '0;
    else if (en_i)         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gw_frame_sequencer.sv
// Frame-level controller for gray_world: checks Nrows x Ncol geometry and sequences stat_clr/coef_load/out_en.
// Optional idle watchdog built only when GW_WATCHDOG_EN is defined.
module gw_frame_sequencer
  import gw_pkg::*;
#(
  parameter int Nrows   = 550,
  parameter int Ncol    = 367,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  gw_frame_sequencer_if.slave    s_axis,
  output logic                   stat_clr,
  output logic                   coef_load,
  output logic                   out_en,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_sof,
  output logic                   err_line,
  output logic                   err_timeout
);

  localparam int COL_W = col_w(Ncol);
  localparam int ROW_W = row_w(Nrows);
  localparam logic [COL_W-1:0] NCOL_V    = COL_W'(Ncol);
  localparam logic [COL_W-1:0] NCOL_LAST = COL_W'(Ncol - 1);
  localparam logic [ROW_W-1:0] NROW_LAST = ROW_W'(Nrows - 1);

  gw_state_e              state_q, beat_state_d;
  logic [COL_W-1:0]       col_q, col_base, col_d;
  logic [ROW_W-1:0]       row_q, row_base, row_d;
  logic                   bad_q, bad_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   stat_clr_q, coef_load_q, out_en_q;
  logic                   err_sof_q, err_line_q, err_timeout_q;
  logic                   sof, line_last, line_err, row_end, take;
  logic                   wd_expire;

`ifdef GW_WATCHDOG_EN
  gw_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .clr_i    ((state_q != ST_ACTIVE) || s_axis.tvalid),
    .en_i     ((state_q == ST_ACTIVE) && !s_axis.tvalid),
    .expire_o (wd_expire)
  );
`else
  // Without the watchdog an unfinished frame waits indefinitely.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign wd_expire      = 1'b0;
`endif

  // Beat evaluation: a SOF beat restarts the frame first, then its EOL (if any) is applied.
  always_comb begin
    sof       = s_axis.tvalid && s_axis.tuser;
    col_base  = sof ? '0 : col_q;
    row_base  = sof ? '0 : row_q;
    line_last = (col_base == NCOL_LAST);
    // col saturated at Ncol means this line's error was already reported.
    line_err  = s_axis.tlast ? (!line_last && (col_base != NCOL_V)) : line_last;
    row_end   = s_axis.tlast && (row_base == NROW_LAST);
    col_d     = s_axis.tlast ? '0 : ((col_base == NCOL_V) ? col_base : col_base + 1'b1);
    row_d     = s_axis.tlast ? row_base + 1'b1 : row_base;
    bad_d     = (sof ? 1'b0 : bad_q) | line_err;
    beat_state_d = row_end ? ST_DONE : ST_ACTIVE;
    take      = s_axis.tvalid && ((state_q == ST_ACTIVE) ? !wd_expire : s_axis.tuser);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      bad_q         <= 1'b0;
      frame_cnt_q   <= '0;
      stat_clr_q    <= 1'b0;
      coef_load_q   <= 1'b0;
      out_en_q      <= 1'b0;
      err_sof_q     <= 1'b0;
      err_line_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      stat_clr_q    <= 1'b0;
      coef_load_q   <= 1'b0;
      err_sof_q     <= 1'b0;
      err_line_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: ;
        ST_ACTIVE: begin
          if (wd_expire) begin
            err_timeout_q <= 1'b1;
            state_q       <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (!bad_q) begin
            coef_load_q <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 1'b1;
            out_en_q    <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // A SOF in the DONE cycle overrides the return to IDLE without losing that frame's load.
      if (take) begin
        state_q    <= beat_state_d;
        col_q      <= col_d;
        row_q      <= row_d;
        bad_q      <= bad_d;
        stat_clr_q <= sof;
        err_sof_q  <= sof && (state_q == ST_ACTIVE);
        err_line_q <= line_err;
      end
    end
  end

  assign stat_clr    = stat_clr_q;
  assign coef_load   = coef_load_q;
  assign out_en      = out_en_q;
  assign busy        = (state_q == ST_ACTIVE);
  assign frame_cnt   = frame_cnt_q;
  assign err_sof     = err_sof_q;
  assign err_line    = err_line_q;
  assign err_timeout = err_timeout_q;

endmodule
